// File: rtl/rw_txn_sequencer.sv
// rw_txn_sequencer: generates the start / wr / rd / done strobes that drive
// the read-write checker stage. Each accepted request produces a one-cycle
// start pulse, a contiguous write burst, a contiguous read burst and a done
// pulse. An abort cuts the sequence short with a one-cycle aborted pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (req_ready combinational from state)
//   req_wr_len          write burst length, latched on acceptance
//   req_rd_len          read burst length, latched on acceptance
//   abort               abort of the transaction in flight
//   start, wr, rd       registered phase strobes
//   done, aborted       registered completion / abort pulses
//   busy                registered, high whenever not idle
//   txn_count           saturating count of completed transactions
module rw_txn_sequencer #(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_wr_len,
    input  logic [LEN_W-1:0] req_rd_len,
    input  logic             abort,
    output logic             start,
    output logic             wr,
    output logic             rd,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] wlen_q;
    logic [LEN_W-1:0] rlen_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_nxt;
    logic             abort_hit;

    assign req_ready = (state == S_IDLE);

    // State and burst-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Next-state logic; the counter holds the remaining beats minus one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        abort_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wlen_q != '0) begin
                    state_nxt = S_WRITE;
                    cnt_nxt   = wlen_q - LEN_W'(1);
                end else if (rlen_q != '0) begin
                    state_nxt = S_READ;
                    cnt_nxt   = rlen_q - LEN_W'(1);
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt_q == '0) begin
                    if (rlen_q != '0) begin
                        state_nxt = S_READ;
                        cnt_nxt   = rlen_q - LEN_W'(1);
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    cnt_nxt = cnt_q - LEN_W'(1);
                end
            end
            S_READ: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt_q - LEN_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Burst lengths captured at the handshake so later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wlen_q <= '0;
            rlen_q <= '0;
        end else if (req_valid && req_ready) begin
            wlen_q <= req_wr_len;
            rlen_q <= req_rd_len;
        end
    end

    // Strobes are decoded from the next state so they align with the state cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start   <= 1'b0;
            wr      <= 1'b0;
            rd      <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            busy    <= 1'b0;
        end else begin
            start   <= (state_nxt == S_START);
            wr      <= (state_nxt == S_WRITE);
            rd      <= (state_nxt == S_READ);
            done    <= (state_nxt == S_DONE);
            aborted <= abort_hit;
            busy    <= (state_nxt != S_IDLE);
        end
    end

    // Completed-transaction counter, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if ((state_nxt == S_DONE) && (txn_count != '1)) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule
